// File: rtl/apb_req_arbiter_pkg.sv
// Shared definitions for the APB request arbiter: FSM encoding, default
// widths/timeout and small elaboration helpers.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam int DEF_REQ_NUM      = 2;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_STROBE_WIDTH = 4;
    localparam int DEF_SLAVES_NUM   = 2;
    localparam int DEF_TIMEOUT      = 16;
    localparam int PROT_WIDTH       = 3;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Request-side view of the APB bridge: the arbiter drives the bridge request
// inputs and observes the bridge phase, ready and captured response.
interface apb_req_arbiter_if import apb_pkg::*; #(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int STROBE_WIDTH = DEF_STROBE_WIDTH,
    parameter int SLAVES_NUM   = DEF_SLAVES_NUM
) ();
    logic                    Transfer;
    logic [ADDR_WIDTH-1:0]   ADDR_in;
    logic [DATA_WIDTH-1:0]   DATA_in;
    logic                    WRITE_in;
    logic [STROBE_WIDTH-1:0] STROB_in;
    logic [PROT_WIDTH-1:0]   PROT_in;
    logic [SLAVES_NUM-1:0]   SEL_in;
    logic                    PENABLE;
    logic                    PREADY;
    logic [DATA_WIDTH-1:0]   DATA_out;
    logic                    SLVERR_out;

    modport master (
        output Transfer, ADDR_in, DATA_in, WRITE_in, STROB_in, PROT_in, SEL_in,
        input  PENABLE, PREADY, DATA_out, SLVERR_out
    );

    modport slave (
        input  Transfer, ADDR_in, DATA_in, WRITE_in, STROB_in, PROT_in, SEL_in,
        output PENABLE, PREADY, DATA_out, SLVERR_out
    );
endinterface

// File: rtl/apb_req_arbiter_rr_arbiter.sv
// Round-robin priority picker: searches upward from the slot after last_ptr
// and returns a one-hot grant plus its index.
module rr_arbiter #(
    parameter int REQ_NUM = 2,
    parameter int IDX_W   = 1
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [IDX_W-1:0]   last_ptr,
    output logic [REQ_NUM-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);
    int   cand_s;
    logic hit_s;

    // First requester found after last_ptr (wrapping) wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand_s  = 0;
        hit_s   = 1'b0;
        for (int off = 1; off <= REQ_NUM; off++) begin
            cand_s = int'(last_ptr) + off;
            cand_s = (cand_s >= REQ_NUM) ? (cand_s - REQ_NUM) : cand_s;
            hit_s  = req[cand_s[IDX_W-1:0]] && !gnt_vld;
            gnt[cand_s[IDX_W-1:0]] = gnt[cand_s[IDX_W-1:0]] | hit_s;
            gnt_idx = hit_s ? cand_s[IDX_W-1:0] : gnt_idx;
            gnt_vld = gnt_vld | hit_s;
        end
    end
endmodule

// File: rtl/apb_req_arbiter.sv
// Arbitrates REQ_NUM requesters onto one APB bridge, one transfer at a time,
// with a wait-state timeout and a one-cycle completion pulse per owner.
module apb_req_arbiter import apb_pkg::*; #(
    parameter int REQ_NUM      = DEF_REQ_NUM,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int STROBE_WIDTH = DEF_STROBE_WIDTH,
    parameter int SLAVES_NUM   = DEF_SLAVES_NUM,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic [REQ_NUM-1:0]               req,
    input  logic [REQ_NUM-1:0]               req_write,
    input  logic [REQ_NUM*ADDR_WIDTH-1:0]    req_addr,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]    req_wdata,
    input  logic [REQ_NUM*STROBE_WIDTH-1:0]  req_strb,
    input  logic [REQ_NUM*PROT_WIDTH-1:0]    req_prot,
    input  logic [REQ_NUM*SLAVES_NUM-1:0]    req_sel,
    output logic [REQ_NUM-1:0]               gnt,
    output logic [REQ_NUM-1:0]               done,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    apb_req_arbiter_if.master                bus
);
    localparam int IDX_W  = idx_width(REQ_NUM);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    arb_state_t              state_r, state_nxt_s;
    logic [REQ_NUM-1:0]      gnt_r, gnt_nxt_s, done_r, done_nxt_s, arb_gnt_s;
    logic [IDX_W-1:0]        owner_r, owner_nxt_s, last_r, last_nxt_s, arb_idx_s;
    logic                    arb_vld_s;
    logic [DATA_WIDTH-1:0]   rdata_r, rdata_nxt_s;
    logic                    err_r, err_nxt_s;
    logic [WAIT_W-1:0]       wait_r, wait_nxt_s;
    logic                    busy_s, complete_s, timeout_hit_s, wait_inc_s;

    rr_arbiter #(
        .REQ_NUM (REQ_NUM),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req      (req),
        .last_ptr (last_r),
        .gnt      (arb_gnt_s),
        .gnt_idx  (arb_idx_s),
        .gnt_vld  (arb_vld_s)
    );

    assign busy_s        = (state_r == ST_BUSY);
    assign complete_s    = busy_s && bus.PENABLE && bus.PREADY;
    assign timeout_hit_s = busy_s && (wait_r == WAIT_W'(TIMEOUT));
    assign wait_inc_s    = busy_s && bus.PENABLE && !bus.PREADY && !timeout_hit_s;
    // Dropping Transfer in the completion cycle keeps the bridge from chaining a second access.
    assign bus.Transfer  = busy_s && !complete_s && !timeout_hit_s;

    // Bridge request fields follow the owner only while a transfer is in flight.
    always_comb begin
        bus.ADDR_in  = '0;
        bus.DATA_in  = '0;
        bus.WRITE_in = 1'b0;
        bus.STROB_in = '0;
        bus.PROT_in  = '0;
        bus.SEL_in   = '0;
        if (busy_s) begin
            bus.ADDR_in  = req_addr [int'(owner_r)*ADDR_WIDTH   +: ADDR_WIDTH];
            bus.DATA_in  = req_wdata[int'(owner_r)*DATA_WIDTH   +: DATA_WIDTH];
            bus.WRITE_in = req_write[owner_r];
            bus.STROB_in = req_strb [int'(owner_r)*STROBE_WIDTH +: STROBE_WIDTH];
            bus.PROT_in  = req_prot [int'(owner_r)*PROT_WIDTH   +: PROT_WIDTH];
            bus.SEL_in   = req_sel  [int'(owner_r)*SLAVES_NUM   +: SLAVES_NUM];
        end else begin
            bus.ADDR_in  = '0;
        end
    end

    // Next-state and next-output logic for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        owner_nxt_s = owner_r;
        last_nxt_s  = last_r;
        done_nxt_s  = '0;
        rdata_nxt_s = '0;
        err_nxt_s   = 1'b0;
        wait_nxt_s  = wait_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_vld_s) begin
                    state_nxt_s = ST_BUSY;
                    gnt_nxt_s   = arb_gnt_s;
                    owner_nxt_s = arb_idx_s;
                    wait_nxt_s  = '0;
                end else begin
                    gnt_nxt_s   = '0;
                end
            end
            ST_BUSY: begin
                if (timeout_hit_s) begin
                    state_nxt_s = ST_DONE;
                    done_nxt_s  = gnt_r;
                    err_nxt_s   = 1'b1;
                end else if (complete_s) begin
                    state_nxt_s = ST_DONE;
                    done_nxt_s  = gnt_r;
                    rdata_nxt_s = req_write[owner_r] ? '0 : bus.DATA_out;
                    err_nxt_s   = bus.SLVERR_out;
                end else if (wait_inc_s) begin
                    wait_nxt_s  = wait_r + WAIT_W'(1);
                end else begin
                    wait_nxt_s  = wait_r;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = '0;
                last_nxt_s  = owner_r;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = '0;
                wait_nxt_s  = '0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer without a done pulse.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r <= ST_IDLE;
            gnt_r   <= '0;
            owner_r <= '0;
            last_r  <= IDX_W'(REQ_NUM - 1);
            done_r  <= '0;
            rdata_r <= '0;
            err_r   <= 1'b0;
            wait_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            owner_r <= owner_nxt_s;
            last_r  <= last_nxt_s;
            done_r  <= done_nxt_s;
            rdata_r <= rdata_nxt_s;
            err_r   <= err_nxt_s;
            wait_r  <= wait_nxt_s;
        end
    end

    assign gnt       = gnt_r;
    assign done      = done_r;
    assign rsp_rdata = rdata_r;
    assign rsp_err   = err_r;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a behavioural APB bridge/slave and
// a transaction-level expectation model checked every cycle.
module tb_apb_req_arbiter;
    localparam int RN = 2, DW = 32, AW = 32, SW = 4, SN = 2, TO = 16;
    localparam int NLIT = 11;

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    logic [RN-1:0]    req;
    logic [RN-1:0]    req_write;
    logic [RN*AW-1:0] req_addr;
    logic [RN*DW-1:0] req_wdata;
    logic [RN*SW-1:0] req_strb;
    logic [RN*3-1:0]  req_prot;
    logic [RN*SN-1:0] req_sel;
    logic [RN-1:0]    gnt, done;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;

    apb_req_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STROBE_WIDTH(SW), .SLAVES_NUM(SN)) bus ();

    apb_req_arbiter #(
        .REQ_NUM(RN), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .STROBE_WIDTH(SW), .SLAVES_NUM(SN), .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot), .req_sel(req_sel), .gnt(gnt), .done(done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .bus(bus)
    );

    always #5 PCLK = ~PCLK;

    // Per-requester request fields
    logic [AW-1:0] f_addr  [RN];
    logic [DW-1:0] f_wdata [RN];
    logic          f_write [RN];
    logic [SW-1:0] f_strb  [RN];
    logic [2:0]    f_prot  [RN];
    logic [SN-1:0] f_sel   [RN];

    always_comb begin
        for (int i = 0; i < RN; i++) begin
            req_addr [i*AW +: AW] = f_addr[i];
            req_wdata[i*DW +: DW] = f_wdata[i];
            req_strb [i*SW +: SW] = f_strb[i];
            req_prot [i*3  +: 3]  = f_prot[i];
            req_sel  [i*SN +: SN] = f_sel[i];
            req_write[i]          = f_write[i];
        end
    end

    // Behavioural bridge (IDLE=0, SETUP=1, ACCESS=2) and slave with wait_n wait states
    int bst = 0;
    int acc_cnt = 0;
    int wait_n = 0;
    logic [DW-1:0] dout_v = '0;
    logic slverr_v = 1'b0;

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            bst <= 0;
            acc_cnt <= 0;
        end else begin
            case (bst)
                0:       bst <= bus.Transfer ? 1 : 0;
                1:       bst <= 2;
                default: bst <= !bus.Transfer ? 0 : (bus.PREADY ? 1 : 2);
            endcase
            acc_cnt <= (bst == 2 && !bus.PREADY) ? acc_cnt + 1 : 0;
        end
    end

    assign bus.PENABLE    = (bst == 2);
    assign bus.PREADY     = (bst == 2) && (acc_cnt >= wait_n);
    assign bus.DATA_out   = dout_v;
    assign bus.SLVERR_out = slverr_v;

    // Expectation model state: phase 0 idle, 1 busy, 2 done, 3 reset
    int       exp_phase = 3;
    int       exp_owner = 0;
    logic     exp_xfer  = 1'b0;
    logic [DW-1:0] exp_rdata = '0;
    logic     exp_err   = 1'b0;
    int       m_last    = RN - 1;
    logic     chk_en    = 1'b0;

    // Hand-computed per-transaction results pinning the model
    logic [RN-1:0] lit_done  [NLIT] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10,
                                        2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    int            lit_xfer  [NLIT] = '{2, 2, 2, 2, 2, 5, 18, 3, 2, 4, 2};
    logic [DW-1:0] lit_rdata [NLIT] = '{32'h0000CAFE, 32'h0000CAFE, 32'h0000CAFE, 32'h0000CAFE,
                                        32'h00000000, 32'h00001234, 32'h00000000, 32'h00000055,
                                        32'h00000077, 32'h00000099, 32'h00000042};
    logic          lit_err   [NLIT] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                        1'b0, 1'b0, 1'b0};

    int n_chk = 0;
    int n_err = 0;
    int ti = 0;
    int xfer_cnt = 0;

    function automatic logic [RN-1:0] oh(input int i);
        logic [RN-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
        n_chk++;
        if (act !== ex) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, ex);
        end
    endtask

    // Compare process: DUT outputs against the model on every falling edge
    initial begin
        forever begin
            @(negedge PCLK);
            if (chk_en) begin
                if (exp_phase == 1)
                    chk("gnt", 64'(gnt), 64'(oh(exp_owner)));
                else if (exp_phase == 3)
                    chk("gnt_reset", 64'(gnt), 64'd0);
                chk("done", 64'(done), (exp_phase == 2) ? 64'(oh(exp_owner)) : 64'd0);
                chk("Transfer", 64'(bus.Transfer), 64'(exp_xfer));
                chk("ADDR_in", 64'(bus.ADDR_in), (exp_phase == 1) ? 64'(f_addr[exp_owner]) : 64'd0);
                chk("DATA_in", 64'(bus.DATA_in), (exp_phase == 1) ? 64'(f_wdata[exp_owner]) : 64'd0);
                chk("WRITE_in", 64'(bus.WRITE_in), (exp_phase == 1) ? 64'(f_write[exp_owner]) : 64'd0);
                chk("STROB_PROT_SEL", 64'({bus.STROB_in, bus.PROT_in, bus.SEL_in}),
                    (exp_phase == 1) ? 64'({f_strb[exp_owner], f_prot[exp_owner], f_sel[exp_owner]}) : 64'd0);
                if (exp_phase == 2 || exp_phase == 3) begin
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
                    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
                end
                xfer_cnt = xfer_cnt + (bus.Transfer ? 1 : 0);
                if (exp_phase == 3) xfer_cnt = 0;
                if (exp_phase == 2) begin
                    if (ti < NLIT) begin
                        chk("lit_done", 64'(done), 64'(lit_done[ti]));
                        chk("lit_xfer_cycles", 64'(xfer_cnt), 64'(lit_xfer[ti]));
                        chk("lit_rdata", 64'(rsp_rdata), 64'(lit_rdata[ti]));
                        chk("lit_err", 64'(rsp_err), 64'(lit_err[ti]));
                    end else begin
                        chk("lit_index", 64'(ti), 64'(NLIT - 1));
                    end
                    ti++;
                    xfer_cnt = 0;
                end
            end
        end
    end

    task automatic set_idle();
        exp_phase = 0;
        exp_xfer  = 1'b0;
        exp_rdata = '0;
        exp_err   = 1'b0;
    endtask

    // One transaction: IDLE cycle, BUSY for 3+min(wait,TIMEOUT) cycles, DONE cycle
    task automatic run_txn(input logic [RN-1:0] rq, input int wn, input logic [DW-1:0] dv,
                           input logic se, input int drop_k, input bit keep);
        int owner;
        int len;
        bit to;
        req = rq;
        wait_n = wn;
        dout_v = dv;
        slverr_v = se;
        set_idle();
        owner = -1;
        for (int o = 1; o <= RN; o++) begin
            int c;
            c = (m_last + o) % RN;
            if (owner < 0 && rq[c]) owner = c;
        end
        to  = (wn >= TO);
        len = 3 + (to ? TO : wn);
        for (int k = 1; k <= len; k++) begin
            @(posedge PCLK); #1;
            if (k == drop_k) req[owner] = 1'b0;
            exp_phase = 1;
            exp_owner = owner;
            exp_xfer  = (k < len);
        end
        @(posedge PCLK); #1;
        exp_phase = 2;
        exp_xfer  = 1'b0;
        exp_rdata = (to || f_write[owner]) ? '0 : dv;
        exp_err   = to ? 1'b1 : se;
        if (!keep) req = '0;
        m_last = owner;
        @(posedge PCLK); #1;
        set_idle();
    endtask

    initial begin
        req = '0;
        f_addr[0] = 32'h0000_0010; f_wdata[0] = 32'hA5A5_A5A5; f_write[0] = 1'b0;
        f_strb[0] = 4'hF; f_prot[0] = 3'b010; f_sel[0] = 2'b01;
        f_addr[1] = 32'h2000_0040; f_wdata[1] = 32'h1111_2222; f_write[1] = 1'b0;
        f_strb[1] = 4'h3; f_prot[1] = 3'b101; f_sel[1] = 2'b10;
        exp_phase = 3;
        @(posedge PCLK); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        set_idle();

        // Both requesting after reset: 01,10,01,10
        run_txn(2'b11, 0, 32'h0000CAFE, 1'b0, 0, 1'b1);
        run_txn(2'b11, 0, 32'h0000CAFE, 1'b0, 0, 1'b1);
        run_txn(2'b11, 0, 32'h0000CAFE, 1'b0, 0, 1'b1);
        run_txn(2'b11, 0, 32'h0000CAFE, 1'b0, 0, 1'b0);
        // Zero-wait write to 0x10
        f_write[0] = 1'b1;
        run_txn(2'b01, 0, 32'h0000DEAD, 1'b0, 0, 1'b0);
        f_write[0] = 1'b0;
        // Read with 3 wait states
        run_txn(2'b10, 3, 32'h00001234, 1'b0, 0, 1'b0);
        // PREADY never rises: timeout
        run_txn(2'b01, 99, 32'h0000BEEF, 1'b0, 0, 1'b0);
        // Slave error, then a normal grant
        run_txn(2'b10, 1, 32'h00000055, 1'b1, 0, 1'b0);
        run_txn(2'b01, 0, 32'h00000077, 1'b0, 0, 1'b0);
        // Requester drops req mid-transfer
        run_txn(2'b10, 2, 32'h00000099, 1'b0, 2, 1'b0);

        // Reset during BUSY
        req = 2'b01;
        wait_n = 5;
        set_idle();
        for (int k = 1; k <= 3; k++) begin
            @(posedge PCLK); #1;
            exp_phase = 1;
            exp_owner = 0;
            exp_xfer  = 1'b1;
        end
        @(posedge PCLK); #2;
        PRESET = 1'b1;
        exp_phase = 3;
        exp_xfer  = 1'b0;
        exp_rdata = '0;
        exp_err   = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        req = 2'b11;
        PRESET = 1'b0;
        m_last = RN - 1;
        set_idle();
        run_txn(2'b11, 0, 32'h00000042, 1'b0, 0, 1'b0);

        @(posedge PCLK); #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter REQ_NUM SHALL default to 2 and set the number of requesters.
REQ-003 Parameter DATA_WIDTH SHALL default to 32 and set the data width.
REQ-004 Parameter ADDR_WIDTH SHALL default to 32 and set the address width.
REQ-005 Parameter STROBE_WIDTH SHALL default to 4 and set the strobe width.
REQ-006 Parameter SLAVES_NUM SHALL default to 2 and set the select width.
REQ-007 Parameter TIMEOUT SHALL default to 16 and set the maximum wait-state cycles.
REQ-008 The block SHALL have these ports, one per line (name, direction, width, meaning):
 PCLK  in  1  clock
 PRESET  in  1  async active-high reset
 req  in  REQ_NUM  per-requester request
 req_write  in  REQ_NUM  per-requester 1=write
 req_addr  in  REQ_NUM*ADDR_WIDTH  packed addresses, index i at [i*AW +: AW]
 req_wdata  in  REQ_NUM*DATA_WIDTH  packed write data
 req_strb  in  REQ_NUM*STROBE_WIDTH  packed strobes
 req_prot  in  REQ_NUM*3  packed protection
 req_sel  in  REQ_NUM*SLAVES_NUM  packed slave selects
 gnt  out  REQ_NUM  one-hot, the current owner
 done  out  REQ_NUM  one-cycle completion pulse
 rsp_rdata  out  DATA_WIDTH  read data, valid with done
 rsp_err  out  1  error, valid with done
 Transfer, ADDR_in, DATA_in, WRITE_in, STROB_in, PROT_in, SEL_in  out  bridge widths  drive the APB bridge request inputs
 PENABLE, PREADY  in  1  observed APB phase and ready
 DATA_out, SLVERR_out  in  DATA_WIDTH, 1  bridge-captured read data and error

Function
REQ-009 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-010 In IDLE with any req high, the arbiter SHALL grant round-robin starting at the index after the last granted index, then enter BUSY on the next edge with gnt one-hot.
REQ-011 In IDLE with no req high, the FSM SHALL stay in IDLE with gnt=0.
REQ-012 In BUSY, the bridge request outputs SHALL be driven from the granted requester's fields; these are zero in all other states.
REQ-013 Completion SHALL be defined as PENABLE&&PREADY sampled in BUSY.
REQ-014 Transfer SHALL equal (state==BUSY) && !(PENABLE&&PREADY) && !timeout_hit, generated combinationally so the bridge never starts a back-to-back cycle.
REQ-015 On completion, the FSM SHALL go to DONE.
REQ-016 In DONE, done[owner]=1 for exactly one cycle, rsp_rdata=DATA_out (0 for writes) and rsp_err=SLVERR_out; the FSM then returns to IDLE and the last-grant pointer is updated.
REQ-017 A wait counter SHALL increment each BUSY cycle with PENABLE=1 and PREADY=0, and clear on entry to BUSY.
REQ-018 When the wait counter reaches TIMEOUT, timeout_hit SHALL assert, Transfer SHALL drop so the bridge returns to IDLE, and the FSM SHALL enter DONE with rsp_err=1 and rsp_rdata=0.
REQ-019 The counter SHALL saturate and not wrap.
REQ-020 A requester dropping req while in BUSY SHALL be ignored: the transaction completes and done still pulses.
REQ-021 Requesters SHALL hold req and all fields stable until done; a req still high after done is a new request.
REQ-022 When multiple requests arrive simultaneously after reset, index 0 SHALL win.
REQ-023 Total latency SHALL be grant→done = 1 + APB cycles + 1.

Reset
REQ-024 PRESET high SHALL asynchronously force state=IDLE, gnt=0, done=0, rsp_rdata=0, rsp_err=0, wait counter=0, last-grant pointer=REQ_NUM-1 and Transfer=0.
REQ-025 Reset mid-BUSY SHALL abort without a done pulse; the bridge is reset by the same reset.

Structure
REQ-026 Package apb_pkg SHALL hold the FSM state encoding, the default widths and the TIMEOUT default.
REQ-027 The round-robin priority logic SHALL be a sub-module rr_arbiter, which takes req and last pointer and returns a one-hot grant.

Verification
REQ-028 With req=01, a write to addr 0x10, data 0xA5A5A5A5 and PREADY=1: Transfer is high for 2 cycles, then done=01 and rsp_err=0.
REQ-029 With req=11 held for 4 transactions: grants alternate 01,10,01,10.
REQ-030 For a read with PREADY low for 3 cycles and DATA_out=0x1234: done pulses with rsp_rdata=0x1234 and Transfer never re-asserts in the completion cycle.
REQ-031 With PREADY held low: after 16 wait cycles Transfer drops, done pulses and rsp_err=1.
REQ-032 With PSLVERR=1 at completion: rsp_err=1 and the next request is granted normally.
REQ-033 Asserting PRESET during BUSY: all outputs go to 0 immediately and no done pulse occurs.
